multiplier_fsm: RTL and testbench

//  Iterative shift-add unsigned multiplier. It is the inverse-operation companion of dividerFsm
//  and uses the same begin/busy/done job handshake, so a datapath sequencer can issue

---
 rtl/multiplier_fsm.sv | 116 +++++++++++
 tb/tb_multiplier_fsm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_fsm.sv
// ----------------------------------------------------------------------------
// multiplier_fsm
//   Iterative shift-add unsigned multiplier with a begin/busy/done job
//   handshake, the same handshake the divider uses, so a sequencer can drive
//   both through one interface style.
//   ABSTRACT_MODEL=1 computes the product as a*b at the accept edge and keeps
//   the identical FSM, counter and output timing, for use as a reference twin.
//
// Ports
//   i_clk           clock, all flops on posedge
//   i_rst_n         asynchronous reset, active-low
//   i_cg            clock gate; 0 holds every flop
//   i_begin         job request, taken only when !o_busy && i_cg
//   i_multiplicand  operand A (unsigned), captured on accept
//   i_multiplier    operand B (unsigned), captured on accept
//   o_busy          job in progress; i_begin ignored while high
//   o_done          one-cycle pulse (per enabled cycle) marking o_product valid
//   o_product       A*B, stable from o_done until the next accepted job
// ----------------------------------------------------------------------------
module multiplier_fsm #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ABSTRACT_MODEL = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cg,
    input  logic                 i_begin,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;
    logic [2*WIDTH-1:0]   cap_value;

    // One shift-add step: add A<<cnt when the current low bit of B is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
        end
    end

    // The abstract build preloads the full product on accept and simply
    // carries it through the RUN cycles, so only the datapath differs.
    always_comb begin
        cap_value = '0;
        result    = acc_next;
        if (ABSTRACT_MODEL != 0) begin
            cap_value = {{WIDTH{1'b0}}, i_multiplicand} * {{WIDTH{1'b0}}, i_multiplier};
            result    = acc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            acc       <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_product <= '0;
        end else if (i_cg) begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_begin) begin
                        mcand     <= i_multiplicand;
                        mplier    <= i_multiplier;
                        acc       <= cap_value;
                        cnt       <= '0;
                        o_product <= '0;
                        o_busy    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    mplier <= mplier >> 1;
                    if (ABSTRACT_MODEL == 0) begin
                        acc <= acc_next;
                    end
                    if (cnt == CNT_LAST) begin
                        // Explicit wrap: WIDTH need not be a power of two.
                        cnt       <= '0;
                        o_product <= result;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_fsm.sv
module tb_multiplier_fsm;

    localparam int W = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           cg    = 1'b0;
    logic           beg   = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;

    logic           busy0, done0, busy1, done1;
    logic [2*W-1:0] prod0, prod1;

    multiplier_fsm #(.WIDTH(W), .ABSTRACT_MODEL(0)) dut_rtl (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_begin(beg),
        .i_multiplicand(a), .i_multiplier(b),
        .o_busy(busy0), .o_done(done0), .o_product(prod0)
    );

    multiplier_fsm #(.WIDTH(W), .ABSTRACT_MODEL(1)) dut_abs (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_begin(beg),
        .i_multiplicand(a), .i_multiplier(b),
        .o_busy(busy1), .o_done(done1), .o_product(prod1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A job occupies WIDTH enabled cycles after the accept edge; the result is
    // plain A*B, published on the last of those edges.
    int             m_rem  = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_job  = '0;
    logic [2*W-1:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_prod = '0;
            sb.delete();
        end else if (cg) begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (beg) begin
                    m_job  = (2*W)'(a) * (2*W)'(b);
                    m_prod = '0;
                    m_rem  = W;
                    sb.push_back(m_job);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_prod = m_job;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int             done_cnt  = 0;
    logic [2*W-1:0] last_prod = '0;
    logic           done_prev = 1'b0;

    always @(negedge clk) begin
        chk("busy", 64'(busy0), 64'(m_rem != 0));
        chk("done", 64'(done0), 64'(m_done));
        chk("product", 64'(prod0), 64'(m_prod));
        chk("eq_busy", 64'(busy1), 64'(busy0));
        chk("eq_done", 64'(done1), 64'(done0));
        chk("eq_product", 64'(prod1), 64'(prod0));
        if (done0 && !done_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_done: got product %0d expected no done", prod0);
            end else begin
                chk("sb_product", 64'(prod0), 64'(sb.pop_front()));
            end
            done_cnt++;
            last_prod = prod0;
        end
        done_prev = done0;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy0; i++) step();
    endtask

    task automatic wait_done(input int n0, input string name);
        int k;
        for (k = 0; k < 60; k++) begin
            step();
            if (done_cnt > n0) break;
        end
        if (k == 60) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
    endtask

    task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb,
                           input logic [2*W-1:0] exp, input string name);
        int n0;
        wait_idle();
        n0  = done_cnt;
        a   = ja;
        b   = jb;
        beg = 1'b1;
        step();
        beg = 1'b0;
        wait_done(n0, name);
        step();
        chk(name, 64'(last_prod), 64'(exp));
    endtask

    initial begin
        int n0;
        int busy_cycles;

        // Reset held 5 cycles
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_product", 64'(prod0), 64'd0);
        rst_n = 1'b1;
        cg    = 1'b1;
        step();

        // Basic job with busy-length measurement
        n0  = done_cnt;
        a   = 8'd13;
        b   = 8'd11;
        beg = 1'b1;
        step();
        beg = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) busy_cycles++;
            step();
        end
        chk("basic_busy_cycles", 64'(busy_cycles), 64'd8);
        chk("basic_product", 64'(last_prod), 64'd143);
        chk("basic_done_count", 64'(done_cnt - n0), 64'd1);

        // Extremes
        run_job(8'd255, 8'd255, 16'd65025, "max_x_max");
        run_job(8'd0,   8'd200, 16'd0,     "zero_x_200");
        run_job(8'd1,   8'd1,   16'd1,     "one_x_one");

        // i_begin held high; operands change mid-job; second job taken in the done cycle
        wait_idle();
        n0  = done_cnt;
        a   = 8'd7;
        b   = 8'd9;
        beg = 1'b1;
        step();
        a   = 8'd5;
        b   = 8'd6;
        wait_done(n0, "b2b_first");
        chk("b2b_first", 64'(last_prod), 64'd63);
        chk("b2b_busy_again", 64'(busy0), 64'd1);
        beg = 1'b0;
        wait_done(n0 + 1, "b2b_second");
        chk("b2b_second", 64'(last_prod), 64'd30);

        // Clock gate pause mid-job
        wait_idle();
        step();
        n0  = done_cnt;
        a   = 8'd100;
        b   = 8'd3;
        beg = 1'b1;
        step();
        beg = 1'b0;
        step();
        step();
        cg = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("cg_paused_busy", 64'(busy0), 64'd1);
        cg = 1'b1;
        wait_done(n0, "cg_pause");
        chk("cg_pause_product", 64'(last_prod), 64'd300);

        // Reset mid-job: immediate clear, no done
        wait_idle();
        step();
        n0  = done_cnt;
        a   = 8'd100;
        b   = 8'd3;
        beg = 1'b1;
        step();
        beg = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_product", 64'(prod0), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("abort_no_done", 64'(done_cnt - n0), 64'd0);

        // Random traffic, both builds side by side
        for (int i = 0; i < 20000; i++) begin
            cg  = ($urandom % 8) != 0;
            beg = ($urandom % 3) == 0;
            case ($urandom % 6)
                0:       a = '0;
                1:       a = '1;
                default: a = W'($urandom);
            endcase
            case ($urandom % 6)
                0:       b = '0;
                1:       b = '1;
                default: b = W'($urandom);
            endcase
            rst_n = ($urandom % 2500) != 0;
            step();
        end

        // Drain
        rst_n = 1'b1;
        cg    = 1'b1;
        beg   = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
